// File: rtl/apb_req_arbiter_pkg.sv
// apb_arb_pkg: shared FSM state type, default sizes and APB phase detection for apb_req_arbiter
package apb_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} arb_state_e;
  function automatic logic apb_complete(input logic psel, input logic penable, input logic pready);
    return psel & penable & pready;
  endfunction
  function automatic logic apb_setup(input logic psel, input logic penable);
    return psel & ~penable;
  endfunction
endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester handshake plus APB master command/monitor signals
interface apb_req_arbiter_if import apb_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [NREQ-1:0] req, req_write, gnt, done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0] rdata;
  logic err;
  logic Transfer, Read_Write;
  logic [AW-1:0] apb_write_paddr, apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic PSEL, PENABLE, PREADY, PSlavErr;
  logic [DW-1:0] read_dataout;
  modport master(
    output req, req_write, req_addr, req_wdata, PSEL, PENABLE, PREADY, PSlavErr, read_dataout,
    input gnt, done, rdata, err, Transfer, Read_Write, apb_write_paddr, apb_read_paddr, apb_write_data
  );
  modport slave(
    input req, req_write, req_addr, req_wdata, PSEL, PENABLE, PREADY, PSlavErr, read_dataout,
    output gnt, done, rdata, err, Transfer, Read_Write, apb_write_paddr, apb_read_paddr, apb_write_data
  );
endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select, one-hot plus index.
// APB_ARB_PRIORITY_EN makes requester 0 win outright and removes it from the rotation.
module rr_arbiter import apb_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [NREQ-1:0] cand;
  logic [PW:0] s;
`ifdef APB_ARB_PRIORITY_EN
  assign cand = req[0] ? NREQ'(1) : {req[NREQ-1:1], 1'b0};
`else
  assign cand = req;
`endif
  assign any = |cand;
  // Scan from farthest to nearest offset so the first set bit at/after ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (PW + 1)'(i);
      s = (s >= (PW + 1)'(NREQ)) ? s - (PW + 1)'(NREQ) : s;
      if (cand[s[PW-1:0]]) begin
        gnt = NREQ'(1) << s[PW-1:0];
        idx = s[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: serialises per-requester APB transactions onto one APB master.
// Optional APB_ARB_PRIORITY_EN gives requester 0 absolute priority.
module apb_req_arbiter import apb_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic PCLK,
  input logic PRESET,
  apb_req_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  arb_state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, win_gnt;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, win_idx, ptr_nxt;
  logic win_any;
  logic transfer_q, transfer_d, rw_q, rw_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req(bus.req),
    .ptr(ptr_q),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );
  assign ptr_nxt = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    done_d = '0;
    ptr_d = ptr_q;
    idx_d = idx_q;
    transfer_d = transfer_q;
    rw_d = rw_q;
    err_d = err_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (win_any) begin
        state_d = SETUP;
        gnt_d = win_gnt;
        idx_d = win_idx;
        transfer_d = 1'b1;
        rw_d = bus.req_write[win_idx];
        addr_d = bus.req_addr[win_idx*AW +: AW];
        wdata_d = bus.req_wdata[win_idx*DW +: DW];
      end
      SETUP: state_d = apb_setup(bus.PSEL, bus.PENABLE) ? ACCESS : SETUP;
      ACCESS: if (apb_complete(bus.PSEL, bus.PENABLE, bus.PREADY)) begin
        state_d = CAPTURE;
        transfer_d = 1'b0;
        err_d = bus.PSlavErr;
      end
      CAPTURE: begin
        state_d = RESP;
        rdata_d = rw_q ? '0 : bus.read_dataout;
        done_d = gnt_q;
      end
      RESP: begin
        state_d = IDLE;
        gnt_d = '0;
        err_d = 1'b0;
        rdata_d = '0;
`ifdef APB_ARB_PRIORITY_EN
        ptr_d = (idx_q == '0) ? ptr_q : ptr_nxt;
`else
        ptr_d = ptr_nxt;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      gnt_q <= '0;
      done_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      transfer_q <= 1'b0;
      rw_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      transfer_q <= transfer_d;
      rw_q <= rw_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.rdata = rdata_q;
  assign bus.err = err_q;
  assign bus.Transfer = transfer_q;
  assign bus.Read_Write = rw_q;
  assign bus.apb_write_paddr = addr_q;
  assign bus.apb_read_paddr = addr_q;
  assign bus.apb_write_data = wdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed stimulus, APB master stand-in and a transaction-level reference model
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .PCLK(clk),
    .PRESET(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Reference rules: first set bit at/after the pointer; requester 0 pre-empts under the macro.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef APB_ARB_PRIORITY_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (((r >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v == (NREQ'(1) << k)) return k;
    return -1;
  endfunction

  // APB master stand-in: zero-wait setup one cycle after Transfer, slv_wait PREADY-low access cycles.
  int mst = 0;
  int wl = 0;
  int slv_wait = 0;
  int n_setup = 0;
  logic slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;

  task automatic tick();
    logic t, rs;
    t = bus.Transfer;
    rs = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      mst = 0;
      bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PSlavErr = 0; bus.read_dataout = '0;
    end else if (mst == 0) begin
      if (t) begin mst = 1; bus.PSEL = 1; bus.PENABLE = 0; n_setup++; end
    end else if (mst == 1) begin
      mst = 2; bus.PENABLE = 1; wl = slv_wait;
      bus.PREADY = (wl == 0); bus.PSlavErr = (wl == 0) & slv_err;
    end else if (bus.PREADY) begin
      mst = 0;
      bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PSlavErr = 0; bus.read_dataout = slv_rdata;
    end else begin
      wl--;
      bus.PREADY = (wl == 0); bus.PSlavErr = (wl == 0) & slv_err;
    end
  endtask

  // Transaction-level model: grant at request+1, Transfer until completion, done two cycles after completion.
  bit m_busy = 0;
  int m_win = 0, m_ptr = 0, m_gnt_at = 0, m_comp_at = -1, m_done_at = -1;
  logic cur_rw = 0, nxt_rw = 0, m_err = 0;
  logic [AW-1:0] cur_addr = '0, nxt_addr = '0;
  logic [DW-1:0] cur_wdata = '0, nxt_wdata = '0, m_rdata = '0;
  logic [NREQ-1:0] e_gnt, e_done;
  logic e_tr;

  always @(negedge clk) if (mon_en) begin
    if (m_busy && cyc == m_gnt_at) begin cur_rw = nxt_rw; cur_addr = nxt_addr; cur_wdata = nxt_wdata; end
    e_gnt = (m_busy && cyc >= m_gnt_at && (m_done_at < 0 || cyc <= m_done_at)) ? NREQ'(1) << m_win : '0;
    e_done = (m_busy && cyc == m_done_at) ? NREQ'(1) << m_win : '0;
    e_tr = m_busy && cyc >= m_gnt_at && (m_comp_at < 0 || cyc <= m_comp_at);
    chk("gnt", bus.gnt, e_gnt);
    chk("gnt_onehot0", $onehot0(bus.gnt), 1);
    chk("done", bus.done, e_done);
    chk("Transfer", bus.Transfer, e_tr);
    chk("Read_Write", bus.Read_Write, cur_rw);
    chk("apb_write_paddr", bus.apb_write_paddr, cur_addr);
    chk("apb_read_paddr", bus.apb_read_paddr, cur_addr);
    chk("apb_write_data", bus.apb_write_data, cur_wdata);
    if (e_done != '0) begin
      chk("rdata", bus.rdata, m_rdata);
      chk("err", bus.err, m_err);
    end
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_comp_at = -1; m_done_at = -1;
      cur_rw = 0; cur_addr = '0; cur_wdata = '0;
    end else if (m_busy) begin
      if (m_comp_at < 0 && cyc > m_gnt_at && bus.PSEL && bus.PENABLE && bus.PREADY) begin
        m_comp_at = cyc; m_done_at = cyc + 2; m_err = bus.PSlavErr;
      end
      if (m_comp_at >= 0 && cyc == m_comp_at + 1) m_rdata = cur_rw ? '0 : bus.read_dataout;
      if (cyc == m_done_at) begin
        m_busy = 0;
`ifdef APB_ARB_PRIORITY_EN
        m_ptr = (m_win == 0) ? m_ptr : (m_win + 1) % NREQ;
`else
        m_ptr = (m_win + 1) % NREQ;
`endif
      end
    end else if (bus.req != '0) begin
      m_win = pick(bus.req, m_ptr);
      m_busy = 1; m_gnt_at = cyc + 1; m_comp_at = -1; m_done_at = -1;
      nxt_rw = |(bus.req_write & (NREQ'(1) << m_win));
      nxt_addr = AW'(bus.req_addr >> (m_win * AW));
      nxt_wdata = DW'(bus.req_wdata >> (m_win * DW));
    end
  end

  int r_win, r_gcyc, r_ccyc, r_dcyc, r_nwait, r_trlow;
  logic [DW-1:0] r_rdata;
  logic r_err;

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_write[i] = w;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic run_txn(input logic [NREQ-1:0] r);
    int k;
    bus.req = r;
    r_win = -1; r_gcyc = -1; r_ccyc = -1; r_dcyc = -1; r_nwait = 0; r_trlow = 0;
    for (k = 0; k < 20 && bus.gnt == '0; k++) tick();
    if (bus.gnt == '0) begin fail("gnt_wait"); return; end
    r_gcyc = cyc;
    r_win = oh2i(bus.gnt);
    for (k = 0; k < 100 && bus.done == '0; k++) begin
      if (bus.PSEL && bus.PENABLE) begin
        if (bus.PREADY) r_ccyc = cyc; else r_nwait++;
        if (!bus.Transfer) r_trlow++;
      end
      tick();
    end
    if (bus.done == '0) begin fail("done_wait"); return; end
    r_dcyc = cyc;
    r_rdata = bus.rdata;
    r_err = bus.err;
    bus.req = bus.req & ~bus.done;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  int c0, base, prev_d;
  int exp_order[5] = '{0, 1, 2, 3, 0};
`ifdef APB_ARB_PRIORITY_EN
  int exp_pair[3] = '{0, 0, 0};
`else
  int exp_pair[3] = '{0, 1, 0};
`endif

  initial begin
    bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PSlavErr = 0; bus.read_dataout = '0;
    rst = 1;
    tick();
    mon_en = 1;
    tick();
    rst = 0;
    chk("reset_gnt", bus.gnt, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_Transfer", bus.Transfer, 0);
    chk("reset_paddr", bus.apb_read_paddr, 0);

    // single read
    set_req(0, 0, 32'h10, 32'h0);
    slv_wait = 0; slv_err = 0; slv_rdata = 32'hDEADBEEF;
    c0 = cyc;
    run_txn(4'b0001);
    chk("single_win", r_win, 0);
    chk("single_gnt_lat", r_gcyc - c0, 1);
    chk("single_done_lat", r_dcyc - c0, 5);
    chk("single_rdata", r_rdata, 32'hDEADBEEF);
    chk("single_err", r_err, 0);
    chk("single_rw", bus.Read_Write, 0);
    chk("single_addr", bus.apb_read_paddr, 32'h10);
    tick();

    // contention after a fresh reset, pointer at 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, AW'(32'h100 + i * 4), '0);
    prev_d = 0;
    for (int k = 0; k < 5; k++) begin
      slv_rdata = DW'(32'hA000_0000 + k);
      run_txn(4'b1111);
      chk("rr_order", r_win, exp_order[k]);
      chk("rr_rdata", r_rdata, DW'(32'hA000_0000 + k));
      if (k > 0) chk("rr_spacing", r_gcyc - prev_d, 2);
      prev_d = r_dcyc;
      tick();
    end

    // wait states on requester 1 (pointer now 1)
    set_req(1, 0, 32'h44, '0);
    slv_wait = 5; slv_rdata = 32'h1234_5678;
    base = n_setup;
    run_txn(4'b0010);
    chk("ws_win", r_win, 1);
    chk("ws_wait_cycles", r_nwait, 5);
    chk("ws_transfer_low", r_trlow, 0);
    chk("ws_done_after_ready", r_dcyc - r_ccyc, 2);
    chk("ws_rdata", r_rdata, 32'h1234_5678);
    for (int k = 0; k < 4; k++) tick();
    chk("ws_one_transfer", n_setup - base, 1);

    // slave error on a write from requester 2
    set_req(2, 1, 32'h20, 32'h55);
    slv_wait = 0; slv_err = 1; slv_rdata = 32'hFFFF_FFFF;
    run_txn(4'b0100);
    chk("err_win", r_win, 2);
    chk("err_flag", r_err, 1);
    chk("err_rdata", r_rdata, 0);
    chk("err_rw", bus.Read_Write, 1);
    chk("err_paddr", bus.apb_write_paddr, 32'h20);
    chk("err_wdata", bus.apb_write_data, 32'h55);
    slv_err = 0;
    tick();

    // reset in ACCESS aborts the transfer
    set_req(1, 0, 32'h88, '0);
    slv_wait = 3;
    bus.req = 4'b0010;
    for (int k = 0; k < 30 && mst != 2; k++) tick();
    if (mst != 2) fail("access_wait");
    chk("pre_reset_transfer", bus.Transfer, 1);
    bus.req = '0;
    rst = 1;
    tick();
    rst = 0;
    chk("abort_gnt", bus.gnt, 0);
    chk("abort_transfer", bus.Transfer, 0);
    chk("abort_rw", bus.Read_Write, 0);
    chk("abort_addr", bus.apb_write_paddr, 0);
    chk("abort_wdata", bus.apb_write_data, 0);
    chk("abort_done", bus.done, 0);
    c0 = cyc;
    slv_wait = 0;
    set_req(2, 0, 32'h30, '0);
    run_txn(4'b0100);
    chk("post_reset_win", r_win, 2);
    chk("post_reset_lat", r_gcyc - c0, 1);
    tick();

    // repeated 0011 from pointer 0, then requester 1 alone
    do_reset();
    set_req(0, 0, 32'h0, '0);
    set_req(1, 0, 32'h4, '0);
    for (int k = 0; k < 3; k++) begin
      run_txn(4'b0011);
      chk("pair_win", r_win, exp_pair[k]);
      tick();
    end
    bus.req = '0;
    run_txn(4'b0010);
    chk("solo1_win", r_win, 1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
